// File: rtl/spi_flash_pkg.sv
// Shared constants and types for the SPI flash emulator command path.
// Opcodes, default ID/status bytes, patch window geometry and the sequencer state set.
package spi_flash_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;

    localparam logic [7:0] DEF_STATUS  = 8'h40;
    localparam logic [7:0] DEF_MANU_ID = 8'hC2;
    localparam logic [7:0] DEF_DEV_ID0 = 8'h20;
    localparam logic [7:0] DEF_DEV_ID1 = 8'h19;

    localparam int PATCH_LEN   = 16;
    localparam int PATCH_IDX_W = $clog2(PATCH_LEN);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        RDID,
        RDSR,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_flash_cmd_ctrl_if.sv
// Byte-level link between the SPI shift engine (master) and the command sequencer (slave).
interface spi_flash_cmd_ctrl_if;

    logic       spi_cs;
    logic       spi_rx_strobe;
    logic [7:0] spi_rx_data;
    logic       spi_tx_strobe;
    logic [7:0] spi_tx_data;

    modport master (
        output spi_cs,
        output spi_rx_strobe,
        output spi_rx_data,
        input  spi_tx_strobe,
        input  spi_tx_data
    );

    modport slave (
        input  spi_cs,
        input  spi_rx_strobe,
        input  spi_rx_data,
        output spi_tx_strobe,
        output spi_tx_data
    );

endinterface

// File: rtl/spi_flash_patch_window.sv
// 16-entry byte patch file overlaying the flash image; registered hit flag and data
// are produced one cycle after a fetch request.
module spi_flash_patch_window
    import spi_flash_pkg::*;
#(
    parameter int                ADDR_W       = 24,
    parameter logic [ADDR_W-1:0] PATCH_OFFSET = ADDR_W'(24'h004230)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [PATCH_IDX_W-1:0] idx,
    input  logic [7:0]             wdata,
    input  logic                   fetch_en,
    input  logic [ADDR_W-1:0]      fetch_addr,
    output logic                   hit,
    output logic [7:0]             data
);

    logic [7:0]           patch_reg [PATCH_LEN];
    logic [PATCH_LEN-1:0] wr_sel;
    logic [ADDR_W-1:0]    rel_addr;

    // Unsigned wrap makes addresses below the window land far above PATCH_LEN.
    assign rel_addr = fetch_addr - PATCH_OFFSET;

    generate
        for (genvar gi = 0; gi < PATCH_LEN; gi++) begin : g_wr_sel
            assign wr_sel[gi] = we && (idx == PATCH_IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PATCH_LEN; i++) begin
                patch_reg[i] <= 8'h00;
            end
            hit  <= 1'b0;
            data <= 8'h00;
        end else begin
            for (int i = 0; i < PATCH_LEN; i++) begin
                if (wr_sel[i]) begin
                    patch_reg[i] <= wdata;
                end
            end
            // Reads the pre-write contents when a write hits the same entry.
            if (fetch_en) begin
                hit  <= rel_addr < ADDR_W'(PATCH_LEN);
                data <= patch_reg[rel_addr[PATCH_IDX_W-1:0]];
            end
        end
    end

endmodule

// File: rtl/spi_flash_cmd_ctrl.sv
// SPI flash command sequencer: decodes READ/RDID/RDSR from received bytes and answers
// each strobe two cycles later through a fetch stage and an output mux stage.
module spi_flash_cmd_ctrl
    import spi_flash_pkg::*;
#(
    parameter int                ADDR_W         = 24,
    parameter logic [7:0]        READ_CMD       = OP_READ,
    parameter logic [7:0]        RDID_CMD       = OP_RDID,
    parameter logic [7:0]        RDSR_CMD       = OP_RDSR,
    parameter logic [7:0]        STATUS_REG     = DEF_STATUS,
    parameter logic [7:0]        RDID_MANU_ID   = DEF_MANU_ID,
    parameter logic [7:0]        RDID_DEV_ID0   = DEF_DEV_ID0,
    parameter logic [7:0]        RDID_DEV_ID1   = DEF_DEV_ID1,
    parameter logic [ADDR_W-1:0] PATCH_OFFSET   = ADDR_W'(24'h004230),
    parameter logic [ADDR_W-1:0] TRIGGER_OFFSET = ADDR_W'(24'h04DE70)
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_flash_cmd_ctrl_if.slave    spi,
    output logic [ADDR_W-1:0]      rom_addr,
    input  logic [7:0]             rom_data,
    input  logic                   patch_we,
    input  logic [PATCH_IDX_W-1:0] patch_idx,
    input  logic [7:0]             patch_wdata,
    output logic                   trigger_out,
    output logic                   busy
);

    state_t            state_reg;
    logic [1:0]        byte_cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              s1_valid_reg;
    logic              s1_from_rom_reg;
    logic [7:0]        s1_const_reg;

    logic              rx_fire;
    logic              fetch_en;
    logic [ADDR_W-1:0] shift_addr;
    logic [ADDR_W-1:0] fetch_addr;
    logic              patch_hit;
    logic [7:0]        patch_data;

    // A strobe coinciding with chip-select release is dropped.
    assign rx_fire    = spi.spi_rx_strobe && !spi.spi_cs;
    assign shift_addr = {addr_reg[ADDR_W-9:0], spi.spi_rx_data};
    assign fetch_en   = rx_fire && ((state_reg == ADDR && byte_cnt_reg == 2'd2) || state_reg == DATA);
    assign fetch_addr = (state_reg == DATA) ? addr_reg : shift_addr;

    spi_flash_patch_window #(
        .ADDR_W       (ADDR_W),
        .PATCH_OFFSET (PATCH_OFFSET)
    ) u_patch (
        .clk        (clk),
        .rst        (rst),
        .we         (patch_we),
        .idx        (patch_idx),
        .wdata      (patch_wdata),
        .fetch_en   (fetch_en),
        .fetch_addr (fetch_addr),
        .hit        (patch_hit),
        .data       (patch_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            busy            <= 1'b0;
            byte_cnt_reg    <= 2'd0;
            addr_reg        <= '0;
            rom_addr        <= '0;
            trigger_out     <= 1'b0;
            s1_valid_reg    <= 1'b0;
            s1_from_rom_reg <= 1'b0;
            s1_const_reg    <= 8'hFF;
        end else begin
            trigger_out  <= (state_reg == DATA) && (addr_reg > TRIGGER_OFFSET);
            s1_valid_reg <= 1'b0;
            if (spi.spi_cs) begin
                state_reg    <= IDLE;
                busy         <= 1'b0;
                byte_cnt_reg <= 2'd0;
                addr_reg     <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg <= CMD;
                        busy      <= 1'b1;
                    end
                    CMD: if (spi.spi_rx_strobe) begin
                        byte_cnt_reg <= 2'd0;
                        if (spi.spi_rx_data == READ_CMD) begin
                            state_reg <= ADDR;
                        end else if (spi.spi_rx_data == RDID_CMD) begin
                            state_reg       <= RDID;
                            s1_valid_reg    <= 1'b1;
                            s1_from_rom_reg <= 1'b0;
                            s1_const_reg    <= RDID_MANU_ID;
                        end else if (spi.spi_rx_data == RDSR_CMD) begin
                            state_reg       <= RDSR;
                            s1_valid_reg    <= 1'b1;
                            s1_from_rom_reg <= 1'b0;
                            s1_const_reg    <= STATUS_REG;
                        end else begin
                            state_reg <= IGNORE;
                        end
                    end
                    ADDR: if (spi.spi_rx_strobe) begin
                        // Last address byte doubles as the first fetch.
                        if (byte_cnt_reg == 2'd2) begin
                            state_reg       <= DATA;
                            addr_reg        <= shift_addr + ADDR_W'(1);
                            rom_addr        <= shift_addr;
                            s1_valid_reg    <= 1'b1;
                            s1_from_rom_reg <= 1'b1;
                        end else begin
                            addr_reg     <= shift_addr;
                            byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        end
                    end
                    DATA: if (spi.spi_rx_strobe) begin
                        addr_reg        <= addr_reg + ADDR_W'(1);
                        rom_addr        <= addr_reg;
                        s1_valid_reg    <= 1'b1;
                        s1_from_rom_reg <= 1'b1;
                    end
                    RDID: if (spi.spi_rx_strobe) begin
                        s1_valid_reg    <= 1'b1;
                        s1_from_rom_reg <= 1'b0;
                        case (byte_cnt_reg)
                            2'd0:    s1_const_reg <= RDID_DEV_ID0;
                            2'd1:    s1_const_reg <= RDID_DEV_ID1;
                            default: s1_const_reg <= 8'hFF;
                        endcase
                        if (byte_cnt_reg != 2'd2) begin
                            byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        end
                    end
                    RDSR: if (spi.spi_rx_strobe) begin
                        s1_valid_reg    <= 1'b1;
                        s1_from_rom_reg <= 1'b0;
                        s1_const_reg    <= STATUS_REG;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // rom_data is sampled one cycle after rom_addr is driven, alongside the patch result.
    always_ff @(posedge clk) begin
        if (rst) begin
            spi.spi_tx_strobe <= 1'b0;
            spi.spi_tx_data   <= 8'hFF;
        end else begin
            spi.spi_tx_strobe <= s1_valid_reg && !spi.spi_cs;
            if (s1_valid_reg && !spi.spi_cs) begin
                if (!s1_from_rom_reg) begin
                    spi.spi_tx_data <= s1_const_reg;
                end else if (patch_hit) begin
                    spi.spi_tx_data <= patch_data;
                end else begin
                    spi.spi_tx_data <= rom_data;
                end
            end
        end
    end

    logic unused_rx_fire;
    assign unused_rx_fire = rx_fire;

endmodule

// File: doc/spi_flash_cmd_ctrl.md
# spi_flash_cmd_ctrl

Command sequencer for the SPI flash emulator. It consumes byte strobes from the SPI shift engine (`spi_device`) and decodes READ, RDID and RDSR. For READ it collects a 24-bit address, fetches image bytes from the block-ROM flash image, and overrides a 16-byte patch window loaded from the UART side. It also raises the oscilloscope trigger when the read address passes a configured offset.

## Interface

Parameters:
- `ADDR_W`, 24: flash address width.
- `READ_CMD`, 8'h03: normal read opcode.
- `RDID_CMD`, 8'h9F: JEDEC ID opcode.
- `RDSR_CMD`, 8'h05: read status opcode.
- `STATUS_REG`, 8'h40: status byte returned by RDSR.
- `RDID_MANU_ID`, 8'hC2: first RDID byte.
- `RDID_DEV_ID0`, 8'h20: second RDID byte.
- `RDID_DEV_ID1`, 8'h19: third RDID byte.
- `PATCH_OFFSET`, 24'h004230: first address of the patch window.
- `PATCH_LEN`, 16: patch window length in bytes (fixed at 16).
- `TRIGGER_OFFSET`, 24'h04DE70: trigger threshold.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `spi_cs` in 1: chip select, active low, already 3-flop synchronized.
- `spi_rx_strobe` in 1: one-cycle pulse; a full byte has been received.
- `spi_rx_data` in 8: received byte, valid while `spi_rx_strobe` is high.
- `spi_tx_strobe` out 1: one-cycle pulse; load `spi_tx_data` for the next byte.
- `spi_tx_data` out 8: byte to shift out.
- `rom_addr` out ADDR_W: flash ROM read address; registered.
- `rom_data` in 8: ROM output, valid 1 cycle after `rom_addr`.
- `patch_we` in 1: patch register write enable.
- `patch_idx` in 4: patch register index.
- `patch_wdata` in 8: patch register write data.
- `trigger_out` out 1: high while a READ address is greater than `TRIGGER_OFFSET`.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation

States and transitions:
- **IDLE**: wait for `spi_cs` low, then go to CMD.
- **CMD**: on `spi_rx_strobe`, decode the opcode:
  - READ goes to ADDR with the byte counter at 0.
  - RDID goes to RDID with the counter at 0.
  - RDSR goes to RDSR.
  - Any other opcode goes to IGNORE.
- **ADDR**: collect 3 bytes, MSB first, into `addr[23:16]`, then `[15:8]`, then `[7:0]`. The third strobe starts the first fetch and moves to DATA.
- **DATA**: each `spi_rx_strobe` (a dummy byte from the host) fetches the byte at `addr`, then `addr <= addr + 1`. The address wraps modulo 2^ADDR_W.
- **RDID**: each strobe, including the opcode strobe, emits the next byte: MANU_ID, DEV_ID0, DEV_ID1, then 8'hFF for every later byte.
- **RDSR**: emits `STATUS_REG` on the opcode strobe and on every later strobe.
- **IGNORE**: no `spi_tx_strobe` until `spi_cs` rises.

Chip-select and reset rules:
- `spi_cs` high in any state sends the FSM to IDLE on the next cycle. This clears the byte counter and `addr`, and cancels any pending `spi_tx_strobe`.
- `spi_cs` rising in the same cycle as `spi_rx_strobe`: `spi_cs` wins and the byte is dropped.

Patch window:
- 16 x 8 registers. A fetch whose address lies in [PATCH_OFFSET, PATCH_OFFSET+15] returns `patch[addr - PATCH_OFFSET]` instead of `rom_data`.
- A write to the entry being fetched in the same cycle returns the old value.
- Patch registers are not cleared by `spi_cs`. `rst` clears them to 8'h00.

Trigger:
- `trigger_out` is registered `(state == DATA) && (addr > TRIGGER_OFFSET)`.
- It drops to 0 on the cycle after the FSM leaves DATA.

Reset values:
- Outputs: `spi_tx_strobe` 0, `spi_tx_data` 8'hFF, `rom_addr` 0, `trigger_out` 0, `busy` 0.
- Internal: state IDLE, `addr` 0.

## Timing

Response latency:
- Every response `spi_tx_strobe` occurs exactly 2 cycles after the `spi_rx_strobe` that caused it (rx at T, tx at T+2), for READ, RDID and RDSR alike.
- READ pipeline: at T+1, `rom_addr <= addr` and the patch-hit flag and index are registered. At T+2, the data mux drives `spi_tx_data` and `spi_tx_strobe` pulses for 1 cycle.
- RDID/RDSR delay their constant through the same 2-stage pipe.

Throughput and wrap:
- Back-to-back `spi_rx_strobe` is not permitted; the minimum spacing is 8 cycles, guaranteed by the SPI byte time.
- Address wrap: a fetch at 24'hFFFFFF is followed by a fetch at 24'h000000.

## Structure

- Package `spi_flash_pkg` holds:
  - opcode constants;
  - the state enum (IDLE, CMD, ADDR, DATA, RDID, RDSR, IGNORE);
  - `PATCH_LEN`;
  - the default STATUS/ID bytes.
- Sub-module `spi_flash_patch_window` holds the 16 x 8 register file with write port, range compare and registered hit/data outputs.

## Test plan

- **Reset:** assert `rst` for 2 cycles mid-READ. Required: next cycle state IDLE, `spi_tx_strobe` 0, `trigger_out` 0, `spi_tx_data` 8'hFF.
- **RDID:** `spi_cs` low, then bytes 9F, 00, 00, 00. Required: `spi_tx_data` 8'hC2, 8'h20, 8'h19, 8'hFF, each 2 cycles after its rx strobe.
- **READ with patch:** write patch[0..15] = 8'hA0..8'hAF. Send 03 00 42 2E, then 20 dummy bytes. Required:
  - `rom_addr` 0x422E and 0x422F for the first two bytes, which come from ROM;
  - the next 16 bytes are A0..AF;
  - address 0x4240 comes from ROM again.
- **Trigger and wrap:**
  - READ at 0x04DE70 then 2 dummy bytes. Required: `trigger_out` goes high once `addr` becomes 0x04DE71 and falls 1 cycle after `spi_cs` rises.
  - READ at 0xFFFFFF. Required: the second fetch is at `rom_addr` 0x000000.
- **Abort and unknown opcode:**
  - `spi_cs` rises after the 2nd address byte. Required: no `spi_tx_strobe`, `busy` low next cycle.
  - Opcode 0x0B. Required: no `spi_tx_strobe` for 4 following bytes.
